aes_block_packer: RTL

//  Upstream stage of the 128-bit AES encryption core. Collects a byte stream
//  (plain-text message) into 128-bit blocks, MSB-first. The first byte of a

---
 rtl/aes_block_packer.sv | 95 +++++++++
 1 files changed

// File: rtl/aes_block_packer.sv
// aes_block_packer: collects a byte stream into MSB-first blocks for the AES
// core's message input. The first byte of a block lands in the top byte lane.
// A final short block is padded with PAD_BYTE. Blocks leave over valid/ready.
module aes_block_packer #(
    parameter int          BLOCK_BYTES = 16,
    parameter logic [7:0]  PAD_BYTE    = 8'h00,
    localparam int         CW          = $clog2(BLOCK_BYTES + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               in_byte,
    input  logic                     in_valid,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic [8*BLOCK_BYTES-1:0] blk_data,
    output logic                     blk_valid,
    input  logic                     blk_ready,
    output logic                     blk_last,
    output logic [CW-1:0]            blk_nbytes
);

    typedef enum logic {
        S_FILL,
        S_HOLD
    } state_t;

    state_t                   r_state;
    logic [CW-1:0]            r_count;
    logic [8*BLOCK_BYTES-1:0] r_acc;
    logic                     r_blk_valid;
    logic                     r_blk_last;
    logic [CW-1:0]            r_blk_nbytes;

    logic                     w_accept;
    logic                     w_close;

    // Upstream may only hand over bytes while filling and out of reset.
    assign in_ready = (r_state == S_FILL) && !rst;
    assign w_accept = in_valid && in_ready;
    // A block closes on its last lane or on the message's final byte.
    assign w_close  = w_accept && (in_last || (r_count == CW'(BLOCK_BYTES - 1)));

    // Fill/hold state machine: accumulates bytes, then holds the block until taken.
    always_ff @(posedge clk) begin
        // NOTE: every register here uses <= so all updates see the pre-edge values.
        if (rst) begin
            // NOTE: the accumulator is reset on purpose; its pad value becomes
            // the visible filler of a short block, so it is not don't-care state.
            r_state      <= S_FILL;
            r_count      <= '0;
            r_acc        <= {BLOCK_BYTES{PAD_BYTE}};
            r_blk_valid  <= 1'b0;
            r_blk_last   <= 1'b0;
            r_blk_nbytes <= '0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        for (int b = 0; b < BLOCK_BYTES; b++) begin
                            if (r_count == CW'(b)) begin
                                r_acc[8*(BLOCK_BYTES-1-b) +: 8] <= in_byte;
                            end
                        end
                        r_count <= r_count + 1'b1;
                        if (w_close) begin
                            r_state      <= S_HOLD;
                            r_blk_valid  <= 1'b1;
                            r_blk_last   <= in_last;
                            r_blk_nbytes <= r_count + 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    // The take cycle never accepts a byte; upstream retries next cycle.
                    if (blk_ready) begin
                        r_state     <= S_FILL;
                        r_count     <= '0;
                        r_acc       <= {BLOCK_BYTES{PAD_BYTE}};
                        r_blk_valid <= 1'b0;
                        r_blk_last  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_FILL;
                end
            endcase
        end
    end

    assign blk_data   = r_acc;
    assign blk_valid  = r_blk_valid;
    assign blk_last   = r_blk_last;
    assign blk_nbytes = r_blk_nbytes;

endmodule
